// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings and default widths.
// Imported by the fetch-head sequencer and its return-address stack.
package cpu_pkg;

    localparam int AW_DEF = 8;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_CALL   = 2'b10;
    localparam logic [1:0] PC_RET    = 2'b11;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between branch decode, stall control and the PC sequencer.
// master: drives en/sel/target/flag_clr; slave: drives pc and RAS status.
interface pc_sequencer_if #(
    parameter int AW = 8
);

    logic          en;
    logic [1:0]    sel;
    logic [AW-1:0] target;
    logic          flag_clr;
    logic [AW-1:0] pc;
    logic [AW-1:0] ras_top;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    modport master (
        output en, sel, target, flag_clr,
        input  pc, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  en, sel, target, flag_clr,
        output pc, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface

// File: rtl/pc_sequencer_ras_lifo.sv
// Circular return-address stack: push overwrites the oldest entry when full.
// Ports: clk, rst (async low), push, pop, din -> top, empty, full, ovf_evt, unf_evt.
module ras_lifo
    import cpu_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf_evt,
    output logic          unf_evt
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] WP_LAST  = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] wp_q, wp_d, wp_inc, wp_dec;
    logic [CW-1:0] cnt_q, cnt_d;

    assign wp_inc = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? WP_LAST : wp_q - 1'b1;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign ovf_evt = push & full;
    assign unf_evt = pop & empty;

    // Entries are never reset, so hide whatever is left when empty.
    assign top = empty ? '0 : mem_q[wp_dec];

    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (push) begin
            wp_d = wp_inc;
            if (!full) cnt_d = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            wp_d  = wp_dec;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-head program counter: stall, sequential, branch, call and return.
// Ports: clk, rst (async low), bus (slave: en/sel/target/flag_clr in, pc/RAS status out).
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    logic [AW-1:0] pc_q, pc_d, pc_inc;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push, pop;
    logic [AW-1:0] ras_top;
    logic          ras_empty, ras_full;
    logic          ovf_evt, unf_evt;

    assign pc_inc = pc_q + 1'b1;
    assign push   = bus.en & (bus.sel == PC_CALL);
    assign pop    = bus.en & (bus.sel == PC_RET);

    ras_lifo #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf_evt (ovf_evt),
        .unf_evt (unf_evt)
    );

    always_comb begin
        pc_d = pc_q;
        if (bus.en) begin
            unique case (bus.sel)
                PC_SEQ:    pc_d = pc_inc;
                PC_BRANCH: pc_d = bus.target;
                PC_CALL:   pc_d = bus.target;
                PC_RET:    pc_d = ras_empty ? pc_inc : ras_top;
                default:   pc_d = pc_inc;
            endcase
        end
    end

    // A new event in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.flag_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_evt) ovf_d = 1'b1;
        if (unf_evt) unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ras_top   = ras_top;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed steps queue expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.AW(8)) bus ();

    pc_sequencer #(
        .AW        (8),
        .RAS_DEPTH (4),
        .RESET_PC  (8'h10)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, ras_top, empty, full, ovf, unf}
    logic [19:0] exp_q [$];
    string       name_q [$];
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [19:0] e;
            logic [19:0] a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.pc, bus.ras_top, bus.ras_empty, bus.ras_full,
                 bus.ras_ovf, bus.ras_unf};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got pc=%h top=%h e=%b f=%b o=%b u=%b, want pc=%h top=%h e=%b f=%b o=%b u=%b",
                         n, a[19:12], a[11:4], a[3], a[2], a[1], a[0],
                         e[19:12], e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic expect_now(input logic [7:0] pc, input logic [7:0] top,
                              input logic e, input logic f,
                              input logic o, input logic u,
                              input string n);
        exp_q.push_back({pc, top, e, f, o, u});
        name_q.push_back(n);
    endtask

    task automatic step(input logic en, input logic [1:0] sel,
                        input logic [7:0] tgt, input logic clr,
                        input logic [7:0] pc, input logic [7:0] top,
                        input logic e, input logic f,
                        input logic o, input logic u,
                        input string n);
        bus.en       = en;
        bus.sel      = sel;
        bus.target   = tgt;
        bus.flag_clr = clr;
        @(posedge clk);
        expect_now(pc, top, e, f, o, u, n);
        @(negedge clk);
    endtask

    localparam logic [1:0] SQ = 2'b00;
    localparam logic [1:0] BR = 2'b01;
    localparam logic [1:0] CL = 2'b10;
    localparam logic [1:0] RT = 2'b11;

    initial begin
        bus.en       = 1'b0;
        bus.sel      = SQ;
        bus.target   = 8'h00;
        bus.flag_clr = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1 expect_now(8'h10, 8'h00, 1, 0, 0, 0, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, SQ, 8'h00, 0, 8'h11, 8'h00, 1, 0, 0, 0, "seq1");
        step(1, SQ, 8'h00, 0, 8'h12, 8'h00, 1, 0, 0, 0, "seq2");
        step(1, SQ, 8'h00, 0, 8'h13, 8'h00, 1, 0, 0, 0, "seq3");
        step(1, BR, 8'hFF, 0, 8'hFF, 8'h00, 1, 0, 0, 0, "br_ff");
        step(1, SQ, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, "wrap");
        step(0, CL, 8'h55, 0, 8'h00, 8'h00, 1, 0, 0, 0, "stall1");
        step(0, CL, 8'h55, 0, 8'h00, 8'h00, 1, 0, 0, 0, "stall2");

        step(1, BR, 8'h20, 0, 8'h20, 8'h00, 1, 0, 0, 0, "br_20");
        step(1, CL, 8'h40, 0, 8'h40, 8'h21, 0, 0, 0, 0, "call_40");
        step(1, CL, 8'h60, 0, 8'h60, 8'h41, 0, 0, 0, 0, "call_60");
        step(1, RT, 8'h00, 0, 8'h41, 8'h21, 0, 0, 0, 0, "ret_41");
        step(1, RT, 8'h00, 0, 8'h21, 8'h00, 1, 0, 0, 0, "ret_21");

        step(1, BR, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, "br_00");
        step(1, CL, 8'h10, 0, 8'h10, 8'h01, 0, 0, 0, 0, "ovf_c1");
        step(1, CL, 8'h20, 0, 8'h20, 8'h11, 0, 0, 0, 0, "ovf_c2");
        step(1, CL, 8'h30, 0, 8'h30, 8'h21, 0, 0, 0, 0, "ovf_c3");
        step(1, CL, 8'h40, 0, 8'h40, 8'h31, 0, 1, 0, 0, "ovf_c4");
        step(1, CL, 8'h50, 0, 8'h50, 8'h41, 0, 1, 1, 0, "ovf_c5");
        step(1, RT, 8'h00, 0, 8'h41, 8'h31, 0, 0, 1, 0, "ovf_r1");
        step(1, RT, 8'h00, 0, 8'h31, 8'h21, 0, 0, 1, 0, "ovf_r2");
        step(1, RT, 8'h00, 0, 8'h21, 8'h11, 0, 0, 1, 0, "ovf_r3");
        step(1, RT, 8'h00, 0, 8'h11, 8'h00, 1, 0, 1, 0, "ovf_r4");

        step(1, BR, 8'h05, 1, 8'h05, 8'h00, 1, 0, 0, 0, "clr_ovf");
        step(1, RT, 8'h00, 0, 8'h06, 8'h00, 1, 0, 0, 1, "unf");
        step(1, SQ, 8'h00, 1, 8'h07, 8'h00, 1, 0, 0, 0, "clr_unf");
        step(1, RT, 8'h00, 0, 8'h08, 8'h00, 1, 0, 0, 1, "unf2");
        step(1, RT, 8'h00, 1, 8'h09, 8'h00, 1, 0, 0, 1, "set_wins");
        step(1, SQ, 8'h00, 0, 8'h0A, 8'h00, 1, 0, 0, 1, "sticky");
        step(0, RT, 8'h00, 1, 8'h0A, 8'h00, 1, 0, 0, 0, "clr_stall");

        step(1, CL, 8'h80, 0, 8'h80, 8'h0B, 0, 0, 0, 0, "b2b_call");
        step(1, RT, 8'h00, 0, 8'h0B, 8'h00, 1, 0, 0, 0, "b2b_ret");

        step(1, CL, 8'h30, 0, 8'h30, 8'h0C, 0, 0, 0, 0, "chain_c1");
        step(1, CL, 8'h50, 0, 8'h50, 8'h31, 0, 0, 0, 0, "chain_c2");
        bus.en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expect_now(8'h10, 8'h00, 1, 0, 0, 0, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, RT, 8'h00, 0, 8'h11, 8'h00, 1, 0, 0, 1, "post_rst_unf");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined CPU, replacing the fixed 8-bit program counter and the link-register write strobe with one block. It holds the fetch address, supports stall, sequential advance, branch, subroutine call and return, and keeps a hardware return-address stack (RAS) of configurable depth with overflow and underflow reporting. It sits at the head of the fetch stage. Its inputs come from the branch-control decode and the bubble/stall control, and its `pc` output drives instruction memory.

## Interface
- `AW`, 8: address width in bits.
- `RAS_DEPTH`, 4: number of return-address entries. Must be ≥ 2.
- `RESET_PC`, 0: value loaded into `pc` on reset, `AW` bits.

- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserted when 0.
- `en`  in  1: advance enable. When 0, all state holds (stall/bubble).
- `sel`  in  2: next-PC mode. 00 SEQ, 01 BRANCH, 10 CALL, 11 RET.
- `target`  in  AW: branch/call destination.
- `flag_clr`  in  1: clears the sticky `ras_ovf` and `ras_unf` flags.
- `pc`  out  AW: current fetch address (registered).
- `ras_top`  out  AW: top RAS entry. Reads 0 when the RAS is empty.
- `ras_empty`  out  1: RAS count == 0.
- `ras_full`  out  1: RAS count == `RAS_DEPTH`.
- `ras_ovf`  out  1: sticky flag. A CALL was made while the RAS was full.
- `ras_unf`  out  1: sticky flag. A RET was made while the RAS was empty.

## Operation
- The RAS is a circular buffer with a write pointer `wp` (range 0..RAS_DEPTH-1) and a count `cnt` (range 0..RAS_DEPTH).
- Behaviour on a rising edge with `en`=1:
  - SEQ: `pc` ← `pc`+1, modulo 2^AW (wraps from all-ones to 0).
  - BRANCH: `pc` ← `target`. RAS unchanged.
  - CALL:
    - Write `pc`+1 (wrapped) at `wp`, then `wp` ← `wp`+1 mod `RAS_DEPTH`, then `pc` ← `target`.
    - If not full: `cnt` ← `cnt`+1.
    - If full: `cnt` is unchanged, the oldest entry is overwritten, and `ras_ovf` ← 1.
  - RET:
    - If not empty: `pc` ← entry at `wp`-1, `wp` ← `wp`-1 mod `RAS_DEPTH`, `cnt` ← `cnt`-1.
    - If empty: behave as SEQ (`pc` ← `pc`+1), RAS unchanged, `ras_unf` ← 1.
- When `en`=0: `pc`, the RAS contents, `wp` and `cnt` all hold, whatever `sel` is. `flag_clr` still takes effect.
- `flag_clr`=1 clears both sticky flags. If a new overflow or underflow event happens in the same cycle, the set wins.
- `ras_top`, `ras_empty` and `ras_full` are combinational from the registered `cnt`, `wp` and RAS contents.
- RAS entries are not reset; only the pointers and count are. `ras_top` is forced to 0 when the RAS is empty, so stale data never shows.

## Timing
- Reset values (apply immediately on `rst`=0, independent of `clk`):
  - `pc`=`RESET_PC`, `wp`=0, `cnt`=0.
  - `ras_ovf`=0, `ras_unf`=0.
  - `ras_empty`=1, `ras_full`=0, `ras_top`=0.
- Reset release: the first update occurs on the first rising edge with `rst`=1.
- Latency: a `sel`/`target` value sampled at edge N appears on `pc` after edge N, i.e. one cycle. There is no combinational path from `sel`/`target` to `pc`.
- Flags update on the same edge as the triggering CALL or RET.
- Reset asserted mid-sequence, including mid-call-chain, discards all RAS state. The next RET after reset is an underflow.
- Back-to-back CALL/RET across consecutive cycles is legal. A RET immediately after a CALL returns to the CALL's `pc`+1.

## Structure
- Shared package `cpu_pkg`:
  - `sel` encodings as constants: `PC_SEQ`=2'b00, `PC_BRANCH`=2'b01, `PC_CALL`=2'b10, `PC_RET`=2'b11.
  - Default `AW`.
- Sub-module `ras_lifo`, parametrised by `AW` and `RAS_DEPTH`:
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `empty`, `full`, `ovf_evt`, `unf_evt`.
  - Contains the circular buffer and pointer logic.
- `pc_sequencer` contains the `pc` register, the next-PC mux, the sticky flags, and the instance of `ras_lifo`.

## Test plan
- Reset and SEQ: assert `rst`=0 mid-cycle with `RESET_PC`=8'h10. `pc` is 8'h10 immediately. Release, then 3 SEQ cycles → `pc` = 11, 12, 13.
- Wrap and stall:
  - Step 1: BRANCH to 8'hFF.
  - Step 2: SEQ → `pc` = 8'h00.
  - Step 3: `en`=0 for 2 cycles with `sel`=CALL → `pc` stays 8'h00 and `ras_empty` stays 1.
- Nested call/return:
  - At `pc`=8'h20, CALL to 8'h40, then CALL to 8'h60. `ras_top`=8'h41 and `cnt`=2.
  - RET → `pc`=8'h41. RET → `pc`=8'h21 and `ras_empty`=1.
- Overflow (`RAS_DEPTH`=4):
  - Make 5 CALLs from `pc` = 8'h00, 10, 20, 30, 40.
  - Expect `ras_full`=1 and `ras_ovf`=1.
  - 4 RETs return 8'h41, 31, 21, 11. The 8'h01 entry is lost.
- Underflow and flag clear:
  - RET with the RAS empty at `pc`=8'h05 → `pc`=8'h06 and `ras_unf`=1.
  - `flag_clr`=1 → flag is 0 next cycle.
  - `flag_clr` together with another empty RET → flag stays 1.
- Async reset mid-chain: after 2 CALLs, pulse `rst`=0 between edges → `pc`=`RESET_PC`, `ras_empty`=1, `ras_top`=0 before the next edge.
